// File: rtl/instruction_loader.sv
// Byte-serial program loader: assembles little-endian 64-bit words from a
// byte stream into an internal instruction memory and exposes a
// combinational fetch port.
module instruction_loader #(
  parameter int NumInstructions = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        end_load,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        busy,
  output logic        load_done,
  output logic        partial_err,
  output logic [63:0] word_count,
  input  logic [63:0] instructionAddress,
  output logic [63:0] instruction
);

  localparam int AW = (NumInstructions > 1) ? $clog2(NumInstructions) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [63:0] mem [NumInstructions];
  logic [63:0] asm_word;
  logic [2:0]  idx, idx_n;
  logic [63:0] wc_n;
  logic        perr_n;
  logic        accept;
  logic        we;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign wr_addr = word_count[AW-1:0];
  assign rd_addr = instructionAddress[AW-1:0];

  // Status outputs; held low while reset is asserted since reset is synchronous
  always_comb begin
    byte_ready = (state == LOAD) && !reset;
    busy       = (state == LOAD) && !reset;
    load_done  = (state == DONE) && !reset;
  end

  // Next-state, byte acceptance and word-write decisions
  always_comb begin
    state_n = state;
    wc_n    = word_count;
    idx_n   = idx;
    perr_n  = partial_err;
    accept  = 1'b0;
    we      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = LOAD;
          wc_n    = '0;
          idx_n   = '0;
          perr_n  = 1'b0;
        end
      end
      LOAD: begin
        if (start) begin
          // restart wins over everything; same-cycle byte is dropped
          state_n = LOAD;
          wc_n    = '0;
          idx_n   = '0;
          perr_n  = 1'b0;
        end else begin
          accept = byte_valid;
          if (accept) begin
            idx_n = idx + 3'd1;
            if (idx == 3'd7) begin
              we   = 1'b1;
              wc_n = word_count + 64'd1;
            end
          end
          // end_load is evaluated after the same-cycle byte is taken
          if (end_load) begin
            state_n = DONE;
            perr_n  = (idx_n != 3'd0);
            idx_n   = '0;
          end else if (we && (wc_n == 64'(NumInstructions))) begin
            state_n = DONE;
            perr_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters, assembly register and memory
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      word_count  <= '0;
      idx         <= '0;
      partial_err <= 1'b0;
      asm_word    <= '0;
      for (int unsigned i = 0; i < NumInstructions; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state       <= state_n;
      word_count  <= wc_n;
      idx         <= idx_n;
      partial_err <= perr_n;
      if (accept) begin
        asm_word[{idx, 3'b000} +: 8] <= byte_in;
      end
      if (we) begin
        mem[wr_addr] <= {byte_in, asm_word[55:0]};
      end
    end
  end

  // Fetch port: full-width bounds check, zero outside the memory or in reset
  always_comb begin
    instruction = '0;
    if (!reset && (instructionAddress < 64'(NumInstructions))) begin
      instruction = mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed test of instruction_loader: full words, word limit, partial
// words, restart, reset mid-session and out-of-range fetches.
module tb_instruction_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        end_load;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        load_done;
  logic        partial_err;
  logic [63:0] word_count;
  logic [63:0] instructionAddress;
  logic [63:0] instruction;

  int n_assert = 0;
  int n_fail   = 0;

  instruction_loader #(.NumInstructions(15)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .end_load          (end_load),
    .byte_in           (byte_in),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .busy              (busy),
    .load_done         (load_done),
    .partial_err       (partial_err),
    .word_count        (word_count),
    .instructionAddress(instructionAddress),
    .instruction       (instruction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [63:0] addr, input logic [63:0] exp, input string tag);
    instructionAddress = addr;
    #1;
    chk(tag, instruction, exp);
  endtask

  // Word w of the streaming test: byte k is {w[3:0], k[3:0]}
  function automatic logic [63:0] pat(input int w);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'((w << 4) | k);
    return r;
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; end_load = 1'b0;
    byte_in = '0; byte_valid = 1'b0; instructionAddress = '0;

    // Reset state
    tick(); tick();
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, byte_ready}, 64'd0);
    chk("rst_done", {63'd0, load_done}, 64'd0);
    chk("rst_wc", word_count, 64'd0);
    chk("rst_instr", instruction, 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_busy", {63'd0, busy}, 64'd0);

    // One full word 01..08
    do_start();
    chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_ready", {63'd0, byte_ready}, 64'd1);
    chk("t1_wc0", word_count, 64'd0);
    byte_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      byte_in = 8'(i + 1);
      tick();
    end
    byte_valid = 1'b0;
    chk("t1_wc1", word_count, 64'd1);
    rd(64'd0, 64'h0807060504030201, "t1_mem0");
    chk("t1_still_busy", {63'd0, busy}, 64'd1);

    // Stream 15 words up to the limit
    do_start();
    chk("t2_wc0", word_count, 64'd0);
    byte_valid = 1'b1;
    for (int w = 0; w < 15; w++) begin
      for (int k = 0; k < 8; k++) begin
        byte_in = 8'((w << 4) | k);
        tick();
      end
    end
    chk("t2_done", {63'd0, load_done}, 64'd1);
    chk("t2_ready", {63'd0, byte_ready}, 64'd0);
    chk("t2_busy", {63'd0, busy}, 64'd0);
    chk("t2_wc", word_count, 64'd15);
    chk("t2_perr", {63'd0, partial_err}, 64'd0);
    byte_in = 8'hFF;
    tick();
    byte_valid = 1'b0;
    chk("t2_wc_hold", word_count, 64'd15);
    chk("t2_done_hold", {63'd0, load_done}, 64'd1);
    rd(64'd0, pat(0), "t2_mem0");
    rd(64'd14, pat(14), "t2_mem14");
    rd(64'd15, 64'd0, "t2_addr15");
    rd(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "t2_addr_max");
    rd(64'h0000_0001_0000_0000, 64'd0, "t2_addr_trunc");

    // Two words, three stray bytes, then end_load
    do_start();
    byte_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      byte_in = 8'(8'h10 + i);
      tick();
    end
    byte_valid = 1'b0;
    end_load = 1'b1;
    tick();
    end_load = 1'b0;
    chk("t3_done", {63'd0, load_done}, 64'd1);
    chk("t3_wc", word_count, 64'd2);
    chk("t3_perr", {63'd0, partial_err}, 64'd1);
    rd(64'd0, 64'h1716151413121110, "t3_mem0");
    rd(64'd1, 64'h1F1E1D1C1B1A1918, "t3_mem1");
    rd(64'd2, pat(2), "t3_mem2_kept");
    tick();
    chk("t3_perr_hold", {63'd0, partial_err}, 64'd1);

    // Restart mid-word; same-cycle byte dropped
    do_start();
    chk("t4_perr_clr", {63'd0, partial_err}, 64'd0);
    byte_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      byte_in = 8'(8'h30 + i);
      tick();
    end
    byte_in = 8'hEE;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t4_wc_restart", word_count, 64'd0);
    for (int i = 0; i < 8; i++) begin
      byte_in = 8'(8'hA0 + i);
      tick();
    end
    byte_valid = 1'b0;
    chk("t4_wc", word_count, 64'd1);
    chk("t4_busy", {63'd0, busy}, 64'd1);
    rd(64'd0, 64'hA7A6A5A4A3A2A1A0, "t4_mem0");
    rd(64'd1, 64'h1F1E1D1C1B1A1918, "t4_mem1_kept");

    // end_load together with the final byte of a word
    byte_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      byte_in = 8'(8'hB0 + i);
      tick();
    end
    byte_in = 8'hB7;
    end_load = 1'b1;
    tick();
    end_load = 1'b0;
    byte_valid = 1'b0;
    chk("t5_done", {63'd0, load_done}, 64'd1);
    chk("t5_wc", word_count, 64'd2);
    chk("t5_perr", {63'd0, partial_err}, 64'd0);
    rd(64'd1, 64'hB7B6B5B4B3B2B1B0, "t5_mem1");

    // Reset in the middle of a session
    do_start();
    byte_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      byte_in = 8'(8'hC0 + i);
      tick();
    end
    chk("t6_wc1", word_count, 64'd1);
    reset = 1'b1;
    start = 1'b1;
    end_load = 1'b1;
    tick();
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_ready", {63'd0, byte_ready}, 64'd0);
    chk("t6_rst_done", {63'd0, load_done}, 64'd0);
    rd(64'd1, 64'd0, "t6_rst_rd");
    reset = 1'b0;
    start = 1'b0;
    end_load = 1'b0;
    tick();
    tick();
    byte_valid = 1'b0;
    chk("t6_idle_busy", {63'd0, busy}, 64'd0);
    chk("t6_idle_done", {63'd0, load_done}, 64'd0);
    chk("t6_wc", word_count, 64'd0);
    chk("t6_perr", {63'd0, partial_err}, 64'd0);
    rd(64'd0, 64'd0, "t6_mem0");
    rd(64'd14, 64'd0, "t6_mem14");
    rd(64'd15, 64'd0, "t6_addr15");
    rd(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "t6_addr_max");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter NumInstructions, default 15, SHALL set the instruction word depth of the internal memory.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  opens a load session; SHALL be honoured in any non-reset cycle.
REQ-005 end_load  input  1  closes the current load session early.
REQ-006 byte_in  input  8  incoming program byte.
REQ-007 byte_valid  input  1  byte_in is valid this cycle.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 busy  output  1  a load session is active.
REQ-010 load_done  output  1  the last session closed; memory contents are stable.
REQ-011 partial_err  output  1  the last session closed with an incomplete word, which was discarded.
REQ-012 word_count  output  64  number of words written in the current or last session.
REQ-013 instructionAddress  input  64  word index for the fetch read port.
REQ-014 instruction  output  64  fetched word.

Function
REQ-015 The FSM SHALL have three states: IDLE, LOAD and DONE.
REQ-016 byte_ready SHALL equal (state==LOAD); busy SHALL equal (state==LOAD); load_done SHALL equal (state==DONE).
REQ-017 A byte SHALL be accepted exactly on cycles with byte_valid && byte_ready.
REQ-018 Bytes SHALL be assembled little-endian: accepted byte k (0..7) of a word lands in bits [8k+7:8k].
REQ-019 A 3-bit byte index SHALL count accepted bytes and wrap from 7 to 0.
REQ-020 On acceptance of byte 7, mem[word_count] SHALL be written with the full word and word_count SHALL increment, both at the same edge.
REQ-021 A written word SHALL be visible on the read port from the cycle after its write edge.
REQ-022 IDLE/DONE with start=1: next state SHALL be LOAD, with word_count=0, byte index=0, partial_err=0.
REQ-023 LOAD with start=1: the session SHALL restart as in REQ-022; a same-cycle byte SHALL be discarded; earlier written words SHALL remain in memory.
REQ-024 start SHALL take priority over end_load and over word-limit completion.
REQ-025 LOAD with end_load=1: any same-cycle byte SHALL be accepted first (REQ-017..020), then the state SHALL become DONE.
REQ-026 If the byte index is nonzero after that acceptance, the partial word SHALL be discarded and partial_err SHALL become 1.
REQ-027 Reaching the word limit: when a write makes word_count equal NumInstructions, the next state SHALL be DONE with partial_err=0.
REQ-028 No memory write SHALL occur outside LOAD.
REQ-029 instruction SHALL be combinational: mem[instructionAddress] when instructionAddress < NumInstructions, else 64'd0; full 64-bit compare, no truncation.
REQ-030 DONE SHALL hold word_count and partial_err until the next start or reset.

Reset
REQ-031 On reset=1 at a clock edge:
- state = IDLE;
- word_count = 0, byte index = 0, partial_err = 0, assembly register = 0;
- all NumInstructions memory words = 0.
REQ-032 While reset is asserted, byte_ready, busy and load_done SHALL be 0, and the read port SHALL return 0.
REQ-033 Reset SHALL override start, end_load and byte_valid, including mid-session.

Verification
REQ-034 Start, then send bytes 0x01..0x08 with continuous valid -> mem[0]=64'h0807060504030201, word_count=1; read at address 0 returns it one cycle after byte 8.
REQ-035 Start, then stream 15*8 bytes -> DONE with load_done=1, word_count=15; byte_ready=0 on the cycle after the last write; a further valid byte is not accepted.
REQ-036 Start, 2 full words, 3 bytes, end_load -> DONE, word_count=2, partial_err=1, mem[2] unchanged.
REQ-037 Start, 5 bytes, start again, 8 bytes 0xA0..0xA7 -> mem[0]=64'hA7A6A5A4A3A2A1A0, word_count=1.
REQ-038 Reset asserted mid-session after 1 word -> state IDLE, word_count=0, mem[0]=0; read at address 0 returns 0; read at address 15 or 64'hFFFF_FFFF_FFFF_FFFF always returns 0.
REQ-039 End_load with byte 7 valid in the same cycle -> word written, word_count incremented, partial_err=0, state DONE.
